// File: rtl/mem_lsu_if.sv
// Request/response and memory-port bundle for the load/store unit.
// The slave modport is the LSU; the master modport is the requester and memory side.
interface mem_lsu_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  mem_op;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_w;
    logic [DATA_WIDTH-1:0] mem_data_r;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_r,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_op, mem_rw, mem_addr, mem_data_w
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_r,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_op, mem_rw, mem_addr, mem_data_w
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word accesses over a 4-byte memory port,
// sub-word stores done as read-modify-write.
module mem_lsu #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 1024
) (
    input logic      sys_clk,
    input logic      sys_rst,
    mem_lsu_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRd, StMerge, StWr, StErr, StResp} state_e;

    state_e                state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [15:0]           wdata_lo;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  mem_op;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_w;
    logic                  misalign;
    logic                  req_bad;

    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [1:0] size, input logic uns, input logic [DATA_WIDTH-1:0] raw);
        case (size)
            2'b00:   return {{(DATA_WIDTH-8){~uns & raw[7]}}, raw[7:0]};
            2'b01:   return {{(DATA_WIDTH-16){~uns & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [1:0] size, input logic [15:0] lo, input logic [DATA_WIDTH-1:0] raw);
        if (size == 2'b00) return {raw[DATA_WIDTH-1:8], lo[7:0]};
        return {raw[DATA_WIDTH-1:16], lo};
    endfunction

    always_comb begin
        misalign = 1'b0;
        case (bus.req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.req_addr[0];
            2'b10:   misalign = |bus.req_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    assign req_bad = misalign || (bus.req_addr > ADDR_WIDTH'(MEM_SIZE - 4));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= StIdle;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_lo   <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_op     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_data_w <= '0;
        end else begin
            // Pulse-style outputs default low; each state re-asserts what it needs.
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_op    <= 1'b0;
            mem_rw    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q       <= bus.req_we;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                        wdata_lo   <= bus.req_wdata[15:0];
                        if (req_bad) begin
                            state <= StErr;
                        end else begin
                            mem_op   <= 1'b1;
                            mem_addr <= bus.req_addr;
                            if (bus.req_we && bus.req_size == 2'b10) begin
                                state      <= StWr;
                                mem_rw     <= 1'b1;
                                mem_data_w <= bus.req_wdata;
                            end else begin
                                state <= StRd;
                            end
                        end
                    end
                end
                StRd: begin
                    if (we_q) begin
                        state      <= StMerge;
                        mem_op     <= 1'b1;
                        mem_rw     <= 1'b1;
                        mem_data_w <= store_merge(size_q, wdata_lo, bus.mem_data_r);
                    end else begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_extend(size_q, unsigned_q, bus.mem_data_r);
                    end
                end
                StMerge, StWr: begin
                    state     <= StResp;
                    rsp_valid <= 1'b1;
                end
                StErr: begin
                    state     <= StResp;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = (state == StIdle);
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_err    = rsp_err;
    assign bus.rsp_rdata  = rsp_rdata;
    assign bus.mem_op     = mem_op;
    assign bus.mem_rw     = mem_rw;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_data_w = mem_data_w;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: byte-array memory model on the falling edge,
// scoreboard of expected responses, directed cases plus a short random run.
module tb_mem_lsu;

    localparam int unsigned MEM_SIZE = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
        int          exp_ops;
    } sb_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0]  mem  [MEM_SIZE];
    logic [7:0]  gold [MEM_SIZE];
    sb_t         sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          n_ops    = 0;
    int          n_rsp    = 0;
    int          ops_before = 0;
    int          cur_kind = 0;  // 0 load, 1 word store, 2 sub-word store
    int          last_acc = 0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Memory model: acts on the falling edge inside the mem_op cycle.
    always @(negedge sys_clk) begin
        int a;
        logic exp_rw;
        if (bus.mem_op) begin
            n_ops++;
            exp_rw = (cur_kind == 0) ? 1'b0 : (cur_kind == 1) ? 1'b1 : (n_ops - ops_before >= 2);
            check("mem_addr", bus.mem_addr, exp_addr);
            check("mem_rw", 32'(bus.mem_rw), 32'(exp_rw));
            if (bus.mem_addr <= MEM_SIZE - 4) begin
                a = int'(bus.mem_addr);
                if (bus.mem_rw) begin
                    check("mem_data_w", bus.mem_data_w, exp_wdata);
                    {mem[a+3], mem[a+2], mem[a+1], mem[a]} = bus.mem_data_w;
                end else begin
                    bus.mem_data_r = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
                end
            end
        end else begin
            check("mem_rw_idle", 32'(bus.mem_rw), 32'd0);
        end
    end

    // Response monitor / scoreboard consumer.
    always @(negedge sys_clk) begin
        sb_t e;
        if (bus.rsp_valid) begin
            n_rsp++;
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
            if (sb.size() == 0) begin
                check("rsp_spurious", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                check("mem_op_count", 32'(n_ops), 32'(e.exp_ops));
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic hold, input logic abort);
        sb_t         e;
        logic        bad;
        logic [31:0] raw;
        int          a;
        int          budget;
        @(negedge sys_clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        budget = 0;
        while (!bus.req_ready && budget < 20) begin
            @(negedge sys_clk);
            budget++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
              || (addr > MEM_SIZE - 4);
        raw = '0;
        if (!bad) begin
            a   = int'(addr);
            raw = {gold[a+3], gold[a+2], gold[a+1], gold[a]};
        end
        e.err     = bad;
        e.acc_cyc = cyc + 1;
        e.rdata   = '0;
        e.lat     = 1;
        e.exp_ops = n_ops;
        ops_before = n_ops;
        exp_addr   = addr;
        cur_kind   = !we ? 0 : (size == 2'd2) ? 1 : 2;
        if (!bad && !we) begin
            e.exp_ops = n_ops + 1;
            case (size)
                2'd0:    e.rdata = uns ? {24'd0, raw[7:0]} : 32'(signed'(raw[7:0]));
                2'd1:    e.rdata = uns ? {16'd0, raw[15:0]} : 32'(signed'(raw[15:0]));
                default: e.rdata = raw;
            endcase
        end else if (!bad && size == 2'd2) begin
            e.exp_ops = n_ops + 1;
            exp_wdata = wdata;
        end else if (!bad) begin
            e.exp_ops = n_ops + 2;
            e.lat     = 2;
            exp_wdata = raw;
            exp_wdata[7:0] = wdata[7:0];
            if (size == 2'd1) exp_wdata[15:8] = wdata[15:8];
        end
        if (!abort) begin
            sb.push_back(e);
            if (!bad && we) begin
                gold[a] = wdata[7:0];
                if (size != 2'd0) gold[a+1] = wdata[15:8];
                if (size == 2'd2) {gold[a+3], gold[a+2]} = wdata[31:16];
            end
        end
        @(posedge sys_clk);
        last_acc = e.acc_cyc;
        #1;
        // Disturb the request fields so that anything not latched shows up.
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.req_size     = 2'($urandom);
        bus.req_we       = ~we;
        bus.req_unsigned = ~uns;
        if (!hold) bus.req_valid = 1'b0;
        if (abort) begin
            #1 sys_rst = 1'b0;
            #1;
            check("abort_mem_op", 32'(bus.mem_op), 32'd0);
            check("abort_ready", 32'(bus.req_ready), 32'd1);
            @(negedge sys_clk);
            #2 sys_rst = 1'b1;
            repeat (5) @(negedge sys_clk);
            check("abort_no_ops", 32'(n_ops), 32'(ops_before));
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(negedge sys_clk);
            budget++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int a3;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;
        for (int i = 0; i < MEM_SIZE; i++) begin
            gold[i] = 8'($urandom);
            mem[i]  = gold[i];
        end
        {gold[3], gold[2], gold[1], gold[0]} = 32'h00100593;
        {mem[3], mem[2], mem[1], mem[0]}     = 32'h00100593;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_data_r   = '0;

        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mem_op", 32'(bus.mem_op), 32'd0);
        check("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_data_w", bus.mem_data_w, 32'd0);
        #10 sys_rst = 1'b1;

        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("word_load_0", last_rdata, 32'h00100593);
        do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("byte_load_signed", last_rdata, 32'hFFFFFF93);
        do_req(1'b0, 2'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("byte_load_unsigned", last_rdata, 32'h00000093);

        // Sub-word store aborted by reset while in the read phase.
        do_req(1'b1, 2'd0, 1'b0, 32'd0, 32'h000000EE, 1'b0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("abort_mem_kept", last_rdata, 32'h00100593);

        do_req(1'b1, 2'd0, 1'b0, 32'd1, 32'h000000AB, 1'b0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();
        check("rmw_byte_store", last_rdata, 32'h0010AB93);

        do_req(1'b0, 2'd1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
        drain();
        check("half_misaligned_err", 32'(last_err), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'd1020, 32'hCAFEF00D, 1'b0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'd1020, 32'd0, 1'b0, 1'b0);
        drain();
        check("top_word_rdata", last_rdata, 32'hCAFEF00D);

        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        a1 = last_acc;
        do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0);
        a2 = last_acc;
        do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0);
        a3 = last_acc;
        drain();
        check("b2b_gap_1", 32'(a2 - a1), 32'd3);
        check("b2b_gap_2", 32'(a3 - a2), 32'd3);

        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            ad = 32'($urandom_range(0, MEM_SIZE - 1));
            if (r == 0) ad = 32'(1020 + $urandom_range(0, 8));
            else if (r < 8) ad = ad & ((sz == 2'd2) ? ~32'd3 : (sz == 2'd1) ? ~32'd1 : ~32'd0);
            do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, 1'($urandom), 1'b0);
        end
        @(negedge sys_clk);
        bus.req_valid = 1'b0;
        drain();
        repeat (3) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
